// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants and address-width helper for the register file.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;
   localparam int ZERO_REG      = 0;

   function automatic int calc_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Per-register busy bits and sticky double-issue error flag.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w_en,
   input  logic [AW-1:0]    w_addr,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic [DEPTH-1:0] busy_vec,
   output logic             err
);

   logic [DEPTH-1:0] r_busy;
   logic             r_err;
   logic             w_wr_valid;
   logic             w_iss_valid;

   assign w_wr_valid  = w_en   && (w_addr   != AW'(ZERO_REG));
   assign w_iss_valid = iss_en && (iss_addr != AW'(ZERO_REG));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_wr_valid)
            r_busy[w_addr] <= 1'b0;
         // Issue is applied last so a new producer wins over a retiring one.
         if (w_iss_valid)
            r_busy[iss_addr] <= 1'b1;
         if (w_iss_valid && r_busy[iss_addr] && !(w_wr_valid && (w_addr == iss_addr)))
            r_err <= 1'b1;
      end
   end

   assign busy_vec = r_busy;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Two-read/one-write register file with bypass and busy scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ra_en,
   input  logic [AW-1:0]    ra_addr,
   output logic [WIDTH-1:0] ra_data,
   output logic             ra_busy,
   input  logic             rb_en,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] rb_data,
   output logic             rb_busy,
   input  logic             w_en,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic             stall,
   output logic [DEPTH-1:0] busy_vec,
   output logic             err
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_live;

   // While reset is held the write port is dead, so it must not bypass either.
   assign w_wr_live = w_en && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_en && (w_addr != AW'(ZERO_REG))) begin
         r_mem[w_addr] <= w_data;
      end
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy_vec (busy_vec),
      .err      (err)
   );

   always_comb begin
      ra_data = '0;
      ra_busy = 1'b0;
      if (ra_en && (ra_addr != AW'(ZERO_REG))) begin
         if (w_wr_live && (w_addr == ra_addr)) begin
            ra_data = w_data;
         end else begin
            ra_data = r_mem[ra_addr];
            ra_busy = busy_vec[ra_addr];
         end
      end
   end

   always_comb begin
      rb_data = '0;
      rb_busy = 1'b0;
      if (rb_en && (rb_addr != AW'(ZERO_REG))) begin
         if (w_wr_live && (w_addr == rb_addr)) begin
            rb_data = w_data;
         end else begin
            rb_data = r_mem[rb_addr];
            rb_busy = busy_vec[rb_addr];
         end
      end
   end

   assign stall = ra_busy | rb_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed scoreboard bench for regfile_sb (WIDTH=32, DEPTH=32).
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        ra_en, rb_en, w_en, iss_en;
   logic [4:0]  ra_addr, rb_addr, w_addr, iss_addr;
   logic [31:0] ra_data, rb_data, w_data;
   logic        ra_busy, rb_busy, stall, err;
   logic [31:0] busy_vec;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // Reference state, advanced from the spec rules at each edge.
   logic [31:0] m_mem [32];
   logic [31:0] m_busy;
   logic        m_err;

   regfile_sb dut (
      .clk      (clk),
      .reset    (reset),
      .ra_en    (ra_en),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .ra_busy  (ra_busy),
      .rb_en    (rb_en),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .rb_busy  (rb_busy),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .stall    (stall),
      .busy_vec (busy_vec),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic expect_val(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] observed);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h required=<none>", observed);
      end else begin
         e = exp_q.pop_front();
         assert (observed === e.value) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
      m_err  = 1'b0;
   endtask

   // Advance the model with the inputs currently applied, then step past the edge.
   task automatic tick();
      logic [31:0] nb;
      if (!reset) begin
         nb = m_busy;
         if (w_en && w_addr != 5'd0) begin
            m_mem[w_addr] = w_data;
            nb[w_addr]    = 1'b0;
         end
         if (iss_en && iss_addr != 5'd0) begin
            if (m_busy[iss_addr] && !(w_en && w_addr == iss_addr)) m_err = 1'b1;
            nb[iss_addr] = 1'b1;
         end
         m_busy = nb;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_en = 1'b0; w_addr = '0; w_data = '0;
      iss_en = 1'b0; iss_addr = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      ra_en = 1'b0; ra_addr = '0;
      rb_en = 1'b0; rb_addr = '0;
      idle_inputs();
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset state.
      ra_en = 1'b1; ra_addr = 5'd5;
      expect_val("rst_ra_data", 32'h0);
      expect_val("rst_busy_vec", m_busy);
      expect_val("rst_err", {31'b0, m_err});
      expect_val("rst_stall", 32'h0);
      #1;
      check(ra_data);
      check(busy_vec);
      check({31'b0, err});
      check({31'b0, stall});

      // Write then read through storage.
      w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
      tick();
      idle_inputs();
      expect_val("wr5_ra_data", m_mem[5]);
      expect_val("wr5_ra_data_const", 32'hDEADBEEF);
      #1;
      check(ra_data);
      check(ra_data);

      // Zero register: bypass and storage both must read 0.
      w_en = 1'b1; w_addr = 5'd0; w_data = 32'h1234;
      rb_en = 1'b1; rb_addr = 5'd0;
      expect_val("zero_bypass_rb", 32'h0);
      #1;
      check(rb_data);
      tick();
      idle_inputs();
      ra_addr = 5'd0;
      expect_val("zero_read_ra", 32'h0);
      #1;
      check(ra_data);

      // Same-cycle bypass.
      w_en = 1'b1; w_addr = 5'd7; w_data = 32'hA5A5A5A5;
      rb_addr = 5'd7;
      expect_val("bypass_rb_data", 32'hA5A5A5A5);
      expect_val("bypass_rb_busy", 32'h0);
      #1;
      check(rb_data);
      check({31'b0, rb_busy});
      tick();
      idle_inputs();
      expect_val("stored7_rb_data", m_mem[7]);
      #1;
      check(rb_data);

      // Hazard: issue to 3, then read while busy.
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      idle_inputs();
      ra_addr = 5'd3;
      expect_val("haz_busy_vec", m_busy);
      expect_val("haz_ra_busy", 32'h1);
      expect_val("haz_stall", 32'h1);
      #1;
      check(busy_vec);
      check({31'b0, ra_busy});
      check({31'b0, stall});
      w_en = 1'b1; w_addr = 5'd3; w_data = 32'h55;
      expect_val("haz_wb_stall", 32'h0);
      expect_val("haz_wb_ra_data", 32'h55);
      #1;
      check({31'b0, stall});
      check(ra_data);
      tick();
      idle_inputs();
      expect_val("haz_cleared_busy_vec", m_busy);
      expect_val("haz_cleared_bit3", 32'h0);
      #1;
      check(busy_vec);
      check({31'b0, busy_vec[3]});

      // Simultaneous issue and write to 9.
      iss_en = 1'b1; iss_addr = 5'd9;
      w_en = 1'b1; w_addr = 5'd9; w_data = 32'h0000_0999;
      tick();
      idle_inputs();
      rb_addr = 5'd9;
      expect_val("sim_busy_vec", m_busy);
      expect_val("sim_rb_data", m_mem[9]);
      expect_val("sim_rb_busy", 32'h1);
      expect_val("sim_err", {31'b0, m_err});
      #1;
      check(busy_vec);
      check(rb_data);
      check({31'b0, rb_busy});
      check({31'b0, err});

      // Re-issue without write sets the sticky error.
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      idle_inputs();
      expect_val("reissue_err", {31'b0, m_err});
      #1;
      check({31'b0, err});
      tick();
      tick();
      expect_val("err_sticky", 32'h1);
      #1;
      check({31'b0, err});

      // Build busy_vec = 0x208 with reg[3] = 0x55, then reset between edges.
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      idle_inputs();
      expect_val("pre_rst_busy_vec", 32'h0000_0208);
      expect_val("pre_rst_reg3", m_mem[3]);
      #1;
      check(busy_vec);
      ra_addr = 5'd3;
      #1;
      check(ra_data);

      reset = 1'b1;
      model_reset();
      w_en = 1'b1; w_addr = 5'd4; w_data = 32'hCAFEF00D;
      iss_en = 1'b1; iss_addr = 5'd4;
      rb_addr = 5'd4;
      expect_val("async_busy_vec", 32'h0);
      expect_val("async_err", 32'h0);
      expect_val("async_reg3", 32'h0);
      expect_val("async_no_bypass", 32'h0);
      #1;
      check(busy_vec);
      check({31'b0, err});
      check(ra_data);
      check(rb_data);
      tick();
      idle_inputs();
      reset = 1'b0;
      expect_val("rst_write_ignored", m_mem[4]);
      expect_val("rst_issue_ignored", m_busy);
      #1;
      check(rb_data);
      check(busy_vec);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
